// File: rtl/i2s_tx_serializer.sv
// I2S transmit end of the audio chain: buffers strobed 16-bit mono samples in a
// small FIFO and streams each one as a Philips I2S frame on both channels.
module i2s_tx_serializer #(
    parameter int CLK_DIV    = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [15:0]                 sample_in,
    input  logic                        sample_valid,
    output logic                        i2s_bclk,
    output logic                        i2s_lrck,
    output logic                        i2s_sdata,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level,
    output logic                        overflow,
    output logic                        underrun
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int DW = $clog2(CLK_DIV);
    localparam logic [DW-1:0] DIV_LAST  = DW'(CLK_DIV - 1);
    localparam logic [LW-1:0] LEVEL_MAX = LW'(FIFO_DEPTH);

    logic [DW-1:0] div_cnt_r;
    logic [4:0]    bit_cnt_r;
    logic [15:0]   word_r;
    logic [15:0]   mem_r [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;

    logic          div_wrap_s;
    logic          fall_s;
    logic [4:0]    bit_nxt_s;
    logic [3:0]    k_s;
    logic          frame_start_s;
    logic          empty_s;
    logic          full_s;
    logic          pop_s;
    logic          push_s;
    logic          drop_s;
    logic          sdata_nxt_s;

    // Fall-event detection, FIFO push/pop decisions and next serial bit
    always_comb begin
        div_wrap_s    = (div_cnt_r == DIV_LAST);
        fall_s        = div_wrap_s & i2s_bclk;
        bit_nxt_s     = bit_cnt_r + 5'd1;
        k_s           = bit_nxt_s[3:0];
        frame_start_s = fall_s & (bit_nxt_s == 5'd0);
        empty_s       = (fifo_level == '0);
        full_s        = (fifo_level == LEVEL_MAX);
        pop_s         = frame_start_s & ~empty_s;
        push_s        = sample_valid & (~full_s | pop_s);
        drop_s        = sample_valid & full_s & ~pop_s;
        sdata_nxt_s   = 1'b0;
        // Slot 0 of each half-frame carries the LSB of the word current before any pop
        if (k_s == 4'd0) begin
            sdata_nxt_s = word_r[0];
        end else begin
            sdata_nxt_s = word_r[4'd0 - k_s];
        end
    end

    // Clock divider, serial frame state, FIFO pointers/occupancy and status pulses
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt_r  <= '0;
            bit_cnt_r  <= 5'd31;
            word_r     <= 16'h0000;
            wr_ptr_r   <= '0;
            rd_ptr_r   <= '0;
            fifo_level <= '0;
            i2s_bclk   <= 1'b0;
            i2s_lrck   <= 1'b1;
            i2s_sdata  <= 1'b0;
            overflow   <= 1'b0;
            underrun   <= 1'b0;
        end else begin
            overflow <= drop_s;
            underrun <= frame_start_s & empty_s;
            if (div_wrap_s) begin
                div_cnt_r <= '0;
                i2s_bclk  <= ~i2s_bclk;
            end else begin
                div_cnt_r <= div_cnt_r + DW'(1);
            end
            if (fall_s) begin
                bit_cnt_r <= bit_nxt_s;
                i2s_lrck  <= bit_nxt_s[4];
                i2s_sdata <= sdata_nxt_s;
            end
            if (frame_start_s) begin
                word_r <= pop_s ? mem_r[rd_ptr_r] : 16'h0000;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (push_s && !pop_s) begin
                fifo_level <= fifo_level + LW'(1);
            end else if (pop_s && !push_s) begin
                fifo_level <= fifo_level - LW'(1);
            end
        end
    end

    // Sample storage; contents are meaningless outside the occupied window
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= sample_in;
        end
    end
endmodule

// File: tb/tb_i2s_tx_serializer.sv
// Directed self-checking bench for i2s_tx_serializer at CLK_DIV=4, FIFO_DEPTH=4.
module tb_i2s_tx_serializer;
    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] sample_in;
    logic        sample_valid;
    logic        i2s_bclk;
    logic        i2s_lrck;
    logic        i2s_sdata;
    logic [2:0]  fifo_level;
    logic        overflow;
    logic        underrun;

    int checks = 0;
    int errors = 0;
    int e = 0;

    always #5 clk = ~clk;

    i2s_tx_serializer #(.CLK_DIV(4), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst(rst), .sample_in(sample_in), .sample_valid(sample_valid),
        .i2s_bclk(i2s_bclk), .i2s_lrck(i2s_lrck), .i2s_sdata(i2s_sdata),
        .fifo_level(fifo_level), .overflow(overflow), .underrun(underrun)
    );

    // Expected sdata at slot n of a frame carrying word w, previous frame word p
    function automatic logic exp_sdata(input logic [15:0] w, input logic [15:0] p, input int n);
        logic [3:0] idx;
        if (n == 0) return p[0];
        else if (n == 16) return w[0];
        else if (n < 16) begin idx = 4'(16 - n); return w[idx]; end
        else begin idx = 4'(32 - n); return w[idx]; end
    endfunction

    task automatic step;
        @(posedge clk);
        e = e + 1;
        @(negedge clk);
    endtask

    task automatic goto_edge(input int t);
        while (e < t) step();
    endtask

    task automatic do_reset;
        rst = 1'b1; sample_valid = 1'b0; sample_in = 16'h0000;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        e = 0;
    endtask

    task automatic push(input logic [15:0] d);
        sample_in = d; sample_valid = 1'b1;
        step();
        sample_valid = 1'b0;
    endtask

    task automatic test_reset;
        int urc;
        logic exp_b;
        rst = 1'b1; sample_valid = 1'b0; sample_in = 16'h0000;
        repeat (3) @(negedge clk);
        checks++; if (i2s_bclk !== 1'b0) begin errors++; $display("FAIL rst_bclk got %b exp 0", i2s_bclk); end
        checks++; if (i2s_lrck !== 1'b1) begin errors++; $display("FAIL rst_lrck got %b exp 1", i2s_lrck); end
        checks++; if (i2s_sdata !== 1'b0) begin errors++; $display("FAIL rst_sdata got %b exp 0", i2s_sdata); end
        checks++; if (fifo_level !== 3'd0) begin errors++; $display("FAIL rst_level got %0d exp 0", fifo_level); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL rst_overflow got %b exp 0", overflow); end
        checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL rst_underrun got %b exp 0", underrun); end
        rst = 1'b0; e = 0; urc = 0;
        for (int t = 1; t <= 264; t++) begin
            step();
            exp_b = ((e / 4) % 2) == 1;
            checks++;
            if (i2s_bclk !== exp_b) begin errors++; $display("FAIL idle_bclk clk %0d got %b exp %b", e, i2s_bclk, exp_b); end
            if (underrun === 1'b1) urc++;
            if (e == 7) begin
                checks++;
                if (i2s_lrck !== 1'b1) begin errors++; $display("FAIL idle_lrck_pre clk 7 got %b exp 1", i2s_lrck); end
            end
            if (e >= 8 && (e - 8) % 8 == 0) begin
                checks++;
                if (i2s_lrck !== (((e - 8) / 8) % 32 >= 16)) begin
                    errors++; $display("FAIL idle_lrck clk %0d got %b exp %b", e, i2s_lrck, (((e - 8) / 8) % 32 >= 16));
                end
                checks++;
                if (i2s_sdata !== 1'b0) begin errors++; $display("FAIL idle_sdata clk %0d got %b exp 0", e, i2s_sdata); end
            end
        end
        checks++; if (urc != 2) begin errors++; $display("FAIL idle_underrun_count got %0d exp 2", urc); end
        checks++; if (underrun !== 1'b1) begin errors++; $display("FAIL idle_underrun_264 got %b exp 1", underrun); end
    endtask

    task automatic test_single;
        logic [15:0] w [2];
        logic [15:0] p;
        w[0] = 16'hA5C3; w[1] = 16'h0000;
        do_reset();
        goto_edge(1);
        push(16'hA5C3);
        checks++; if (fifo_level !== 3'd1) begin errors++; $display("FAIL single_level_push got %0d exp 1", fifo_level); end
        goto_edge(8);
        checks++; if (fifo_level !== 3'd0) begin errors++; $display("FAIL single_level_pop got %0d exp 0", fifo_level); end
        for (int f = 0; f < 2; f++) begin
            p = (f == 0) ? 16'h0000 : w[f - 1];
            for (int n = 0; n < 32; n++) begin
                goto_edge(8 + 256 * f + 8 * n);
                checks++;
                if (i2s_sdata !== exp_sdata(w[f], p, n)) begin
                    errors++; $display("FAIL single_sdata f%0d n%0d got %b exp %b", f, n, i2s_sdata, exp_sdata(w[f], p, n));
                end
                if (n == 0) begin
                    checks++;
                    if (underrun !== (f == 1)) begin errors++; $display("FAIL single_underrun f%0d got %b exp %b", f, underrun, (f == 1)); end
                end
            end
        end
    endtask

    task automatic test_order;
        logic [15:0] w [4];
        logic [2:0]  lv [4];
        logic [15:0] p;
        w[0] = 16'h8000; w[1] = 16'h7FFF; w[2] = 16'h0001; w[3] = 16'h0000;
        lv[0] = 3'd2; lv[1] = 3'd1; lv[2] = 3'd0; lv[3] = 3'd0;
        do_reset();
        push(16'h8000); push(16'h7FFF); push(16'h0001);
        checks++; if (fifo_level !== 3'd3) begin errors++; $display("FAIL order_level_fill got %0d exp 3", fifo_level); end
        for (int f = 0; f < 4; f++) begin
            p = (f == 0) ? 16'h0000 : w[f - 1];
            for (int n = 0; n < 32; n++) begin
                goto_edge(8 + 256 * f + 8 * n);
                checks++;
                if (i2s_sdata !== exp_sdata(w[f], p, n)) begin
                    errors++; $display("FAIL order_sdata f%0d n%0d got %b exp %b", f, n, i2s_sdata, exp_sdata(w[f], p, n));
                end
                if (n == 0) begin
                    checks++;
                    if (fifo_level !== lv[f]) begin errors++; $display("FAIL order_level f%0d got %0d exp %0d", f, fifo_level, lv[f]); end
                    checks++;
                    if (underrun !== (f == 3)) begin errors++; $display("FAIL order_underrun f%0d got %b exp %b", f, underrun, (f == 3)); end
                end
            end
        end
    endtask

    task automatic test_overflow;
        logic [15:0] d [5];
        logic [15:0] w [5];
        logic [15:0] p;
        d[0] = 16'h1234; d[1] = 16'h5678; d[2] = 16'h9ABC; d[3] = 16'hDEF0; d[4] = 16'hFFFF;
        w[0] = 16'h1234; w[1] = 16'h5678; w[2] = 16'h9ABC; w[3] = 16'hDEF0; w[4] = 16'h0000;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            push(d[i]);
            checks++;
            if (overflow !== (i == 4)) begin errors++; $display("FAIL ovf_pulse push%0d got %b exp %b", i, overflow, (i == 4)); end
            checks++;
            if (fifo_level !== 3'((i < 4) ? i + 1 : 4)) begin
                errors++; $display("FAIL ovf_level push%0d got %0d exp %0d", i, fifo_level, (i < 4) ? i + 1 : 4);
            end
        end
        step();
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_pulse_end got %b exp 0", overflow); end
        for (int f = 0; f < 5; f++) begin
            p = (f == 0) ? 16'h0000 : w[f - 1];
            for (int n = 0; n < 32; n++) begin
                goto_edge(8 + 256 * f + 8 * n);
                checks++;
                if (i2s_sdata !== exp_sdata(w[f], p, n)) begin
                    errors++; $display("FAIL ovf_sdata f%0d n%0d got %b exp %b", f, n, i2s_sdata, exp_sdata(w[f], p, n));
                end
            end
        end
    endtask

    task automatic test_full_pop;
        logic [15:0] w [5];
        logic [15:0] p;
        w[0] = 16'hC001; w[1] = 16'hC002; w[2] = 16'hC003; w[3] = 16'hC004; w[4] = 16'hBEEF;
        do_reset();
        for (int i = 0; i < 4; i++) push(w[i]);
        checks++; if (fifo_level !== 3'd4) begin errors++; $display("FAIL fullpop_level_fill got %0d exp 4", fifo_level); end
        goto_edge(7);
        push(16'hBEEF);
        checks++; if (fifo_level !== 3'd4) begin errors++; $display("FAIL fullpop_level got %0d exp 4", fifo_level); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL fullpop_overflow got %b exp 0", overflow); end
        step();
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL fullpop_overflow_next got %b exp 0", overflow); end
        for (int f = 0; f < 5; f++) begin
            p = (f == 0) ? 16'h0000 : w[f - 1];
            for (int n = 0; n < 32; n++) begin
                goto_edge(8 + 256 * f + 8 * n);
                checks++;
                if (i2s_sdata !== exp_sdata(w[f], p, n)) begin
                    errors++; $display("FAIL fullpop_sdata f%0d n%0d got %b exp %b", f, n, i2s_sdata, exp_sdata(w[f], p, n));
                end
                if (n == 0) begin
                    checks++;
                    if (fifo_level !== 3'(4 - f)) begin errors++; $display("FAIL fullpop_level f%0d got %0d exp %0d", f, fifo_level, 4 - f); end
                end
            end
        end
    endtask

    task automatic test_reset_mid;
        do_reset();
        push(16'h1357); push(16'h2468); push(16'h0F0F);
        goto_edge(168);
        checks++; if (fifo_level !== 3'd2) begin errors++; $display("FAIL mid_level_pre got %0d exp 2", fifo_level); end
        checks++; if (i2s_lrck !== 1'b1) begin errors++; $display("FAIL mid_lrck_pre got %b exp 1", i2s_lrck); end
        rst = 1'b1;
        #1;
        checks++; if (i2s_bclk !== 1'b0) begin errors++; $display("FAIL mid_bclk got %b exp 0", i2s_bclk); end
        checks++; if (i2s_lrck !== 1'b1) begin errors++; $display("FAIL mid_lrck got %b exp 1", i2s_lrck); end
        checks++; if (i2s_sdata !== 1'b0) begin errors++; $display("FAIL mid_sdata got %b exp 0", i2s_sdata); end
        checks++; if (fifo_level !== 3'd0) begin errors++; $display("FAIL mid_level got %0d exp 0", fifo_level); end
        do_reset();
        goto_edge(8);
        checks++; if (underrun !== 1'b1) begin errors++; $display("FAIL mid_underrun got %b exp 1", underrun); end
        checks++; if (i2s_lrck !== 1'b0) begin errors++; $display("FAIL mid_lrck_post got %b exp 0", i2s_lrck); end
        checks++; if (fifo_level !== 3'd0) begin errors++; $display("FAIL mid_level_post got %0d exp 0", fifo_level); end
        step();
        checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL mid_underrun_end got %b exp 0", underrun); end
        for (int n = 0; n < 32; n++) begin
            goto_edge(8 + 8 * n);
            checks++;
            if (i2s_sdata !== 1'b0) begin errors++; $display("FAIL mid_sdata_post n%0d got %b exp 0", n, i2s_sdata); end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_order();
        test_overflow();
        test_full_pop();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
